uart_rx: RTL and testbench

//  Serial-to-parallel UART receiver. Pairs with uart_tx on the far end of the link.

---
 rtl/uart_rx_if.sv | 35 +++
 rtl/uart_rx.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bus of uart_rx: received word, its valid strobe, the busy flag
// and the error strobes. The receiver drives it via the master modport, and the
// consumer reads it via the slave modport.
// Optional feature macro: UART_RX_PARITY_EN adds o_Rx_Parity_Err.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  o_Rx_DV;
  logic [DATA_WIDTH-1:0] o_Rx_Byte;
  logic                  o_Rx_Active;
  logic                  o_Rx_Frame_Err;
`ifdef UART_RX_PARITY_EN
  logic                  o_Rx_Parity_Err;
`endif

  modport master (
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
`ifdef UART_RX_PARITY_EN
    output o_Rx_Parity_Err,
`endif
    output o_Rx_Frame_Err
  );

  modport slave (
    input o_Rx_DV,
    input o_Rx_Byte,
    input o_Rx_Active,
`ifdef UART_RX_PARITY_EN
    input o_Rx_Parity_Err,
`endif
    input o_Rx_Frame_Err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default, LSB first, idle-high line.
// The line is oversampled at i_Clock and each bit is sampled at its midpoint.
// A good frame updates o_Rx_Byte and strobes o_Rx_DV for one cycle.
// A stop bit sampled low strobes o_Rx_Frame_Err instead, and the receiver then
// waits for the line to return high before it accepts another start bit.
// Optional feature macro: UART_RX_PARITY_EN (8E1, adds o_Rx_Parity_Err).
module uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_WIDTH   = 8
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_Serial,
  uart_rx_if.master   rx_bus
);

  localparam int CLK_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CLK_W-1:0] HALF_CNT = CLK_W'(HALF);
  localparam logic [CLK_W-1:0] LAST_CNT = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t                r_State;
  logic                  r_Sync_0;
  logic                  r_Sync_1;
  logic [CLK_W-1:0]      r_Clk_Count;
  logic [IDX_W-1:0]      r_Bit_Idx;
  logic [DATA_WIDTH-1:0] r_Shift;
  logic [DATA_WIDTH-1:0] r_Rx_Byte;
  logic                  r_Rx_DV;
  logic                  r_Rx_Active;
  logic                  r_Rx_Frame_Err;
  logic                  r_Wait_High;
`ifdef UART_RX_PARITY_EN
  logic                  r_Parity;
  logic                  r_Rx_Parity_Err;
`endif
  logic                  w_Rx_S;
  logic                  w_Bit_End;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Sync_0 <= 1'b1;
      r_Sync_1 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the two flops shift one stage per
      // clock; blocking ones would collapse the chain into a single flop.
      r_Sync_0 <= i_Rx_Serial;
      r_Sync_1 <= r_Sync_0;
    end
  end

  assign w_Rx_S    = r_Sync_1;
  assign w_Bit_End = (r_Clk_Count == LAST_CNT);

  // Frame state machine; every output is a register written here.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State         <= S_IDLE;
      r_Clk_Count     <= '0;
      r_Bit_Idx       <= '0;
      r_Shift         <= '0;
      r_Rx_Byte       <= '0;
      r_Rx_DV         <= 1'b0;
      r_Rx_Active     <= 1'b0;
      r_Rx_Frame_Err  <= 1'b0;
      r_Wait_High     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_Parity        <= 1'b0;
      r_Rx_Parity_Err <= 1'b0;
`endif
    end else begin
      case (r_State)
        S_IDLE: begin
          r_Clk_Count    <= '0;
          r_Bit_Idx      <= '0;
          r_Rx_DV        <= 1'b0;
          r_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
          r_Parity        <= 1'b0;
          r_Rx_Parity_Err <= 1'b0;
`endif
          // After a frame error the line may still be low (break): hold off
          // until it is seen high so a break yields exactly one error.
          if (r_Wait_High) begin
            if (w_Rx_S) r_Wait_High <= 1'b0;
          end else if (!w_Rx_S) begin
            r_State <= S_START;
          end
        end

        S_START: begin
          if (r_Clk_Count == HALF_CNT) begin
            r_Clk_Count <= '0;
            if (!w_Rx_S) begin
              r_Rx_Active <= 1'b1;
              r_State     <= S_DATA;
            end else begin
              r_State <= S_IDLE;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + CLK_W'(1);
          end
        end

        S_DATA: begin
          if (!w_Bit_End) begin
            r_Clk_Count <= r_Clk_Count + CLK_W'(1);
          end else begin
            r_Clk_Count        <= '0;
            r_Shift[r_Bit_Idx] <= w_Rx_S;
`ifdef UART_RX_PARITY_EN
            r_Parity <= r_Parity ^ w_Rx_S;
`endif
            if (r_Bit_Idx == LAST_IDX) begin
              r_Bit_Idx <= '0;
`ifdef UART_RX_PARITY_EN
              r_State <= S_PARITY;
`else
              r_State <= S_STOP;
`endif
            end else begin
              r_Bit_Idx <= r_Bit_Idx + IDX_W'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (!w_Bit_End) begin
            r_Clk_Count <= r_Clk_Count + CLK_W'(1);
          end else begin
            r_Clk_Count <= '0;
            r_Parity    <= r_Parity ^ w_Rx_S;
            r_State     <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (!w_Bit_End) begin
            r_Clk_Count <= r_Clk_Count + CLK_W'(1);
          end else begin
            r_Clk_Count <= '0;
            r_Rx_Active <= 1'b0;
            r_State     <= S_CLEANUP;
            if (w_Rx_S) begin
`ifdef UART_RX_PARITY_EN
              // r_Parity holds the XOR of data and parity bits; 1 means odd.
              if (r_Parity) begin
                r_Rx_Parity_Err <= 1'b1;
              end else begin
                r_Rx_Byte <= r_Shift;
                r_Rx_DV   <= 1'b1;
              end
`else
              r_Rx_Byte <= r_Shift;
              r_Rx_DV   <= 1'b1;
`endif
            end else begin
              r_Rx_Frame_Err <= 1'b1;
              r_Wait_High    <= 1'b1;
            end
          end
        end

        S_CLEANUP: begin
          r_Rx_DV        <= 1'b0;
          r_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
          r_Rx_Parity_Err <= 1'b0;
`endif
          r_State <= S_IDLE;
        end

        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign rx_bus.o_Rx_DV        = r_Rx_DV;
  assign rx_bus.o_Rx_Byte      = r_Rx_Byte;
  assign rx_bus.o_Rx_Active    = r_Rx_Active;
  assign rx_bus.o_Rx_Frame_Err = r_Rx_Frame_Err;
`ifdef UART_RX_PARITY_EN
  assign rx_bus.o_Rx_Parity_Err = r_Rx_Parity_Err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, glitch, frame error, break, mid-frame
// reset and a randomized stream, all scored against a frame-level model.
// Optional feature macro: UART_RX_PARITY_EN adds the 8E1 parity cases.
module tb_uart_rx;

  localparam int CPB = 87;
  localparam int DW  = 8;

  logic clk;
  logic rst;
  logic rx;

  uart_rx_if #(.DATA_WIDTH(DW)) rx_if ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Rx_Serial (rx),
    .rx_bus      (rx_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples outputs on the falling edge, away from the active edge.
  int cyc = 0;
  int dv_count = 0;
  int fe_count = 0;
  int pe_count = 0;
  int both_count = 0;
  int dv_cyc_last = 0;
  int dv_cyc_prev = 0;
  int act_run = 0;
  int last_act_len = 0;
  bit act_seen = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rx_if.o_Rx_DV === 1'b1) begin
      dv_count++;
      dv_cyc_prev = dv_cyc_last;
      dv_cyc_last = cyc;
    end
    if (rx_if.o_Rx_Frame_Err === 1'b1) fe_count++;
    if (rx_if.o_Rx_DV === 1'b1 && rx_if.o_Rx_Frame_Err === 1'b1) both_count++;
`ifdef UART_RX_PARITY_EN
    if (rx_if.o_Rx_Parity_Err === 1'b1) pe_count++;
    if (rx_if.o_Rx_Parity_Err === 1'b1 && rx_if.o_Rx_DV === 1'b1) both_count++;
`endif
    if (rx_if.o_Rx_Active === 1'b1) begin
      act_run++;
      act_seen = 1'b1;
    end else if (act_run != 0) begin
      last_act_len = act_run;
      act_run = 0;
    end
  end

  // Frame-level reference model: expected event counts and the last good word.
  int exp_dv = 0;
  int exp_fe = 0;
  int exp_pe = 0;
  logic [DW-1:0] exp_byte = '0;

  task automatic drive_bit(input logic b, input int cycles);
    rx = b;
    repeat (cycles) @(negedge clk);
  endtask

  // Sends one frame; stop_b is the stop-bit level, par_flip inverts the even
  // parity bit (parity build only). Updates the model from the frame rules.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic par_flip);
    logic par_bit;
    logic odd;
    par_bit = (^d) ^ par_flip;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DW; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit, CPB);
    odd = (^d) ^ par_bit;
`else
    odd = 1'b0;
`endif
    drive_bit(stop_b, CPB);
    if (!stop_b)  exp_fe++;
    else if (odd) exp_pe++;
    else begin
      exp_dv++;
      exp_byte = d;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_dv_count"}, dv_count, exp_dv);
    check({tag, "_fe_count"}, fe_count, exp_fe);
    check({tag, "_pe_count"}, pe_count, exp_pe);
    check({tag, "_byte"}, {24'h0, rx_if.o_Rx_Byte}, {24'h0, exp_byte});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dv"}, {31'h0, rx_if.o_Rx_DV}, 32'h0);
    check({tag, "_byte"}, {24'h0, rx_if.o_Rx_Byte}, 32'h0);
    check({tag, "_active"}, {31'h0, rx_if.o_Rx_Active}, 32'h0);
    check({tag, "_ferr"}, {31'h0, rx_if.o_Rx_Frame_Err}, 32'h0);
  endtask

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    drive_bit(1'b1, 2 * CPB);

    // Single 0xA5 frame.
    send_frame(8'hA5, 1'b1, 1'b0);
    drive_bit(1'b1, CPB);
    check_model("a5");
    check("a5_active_len_in_range",
          {31'h0, (last_act_len >= (17 * CPB) / 2 && last_act_len <= 10 * CPB)}, 32'h1);

    // 0x00 then 0xFF with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0);
    check_model("b2b_00");
    send_frame(8'hFF, 1'b1, 1'b0);
    check_model("b2b_ff");
    check("b2b_dv_spacing_in_range",
          {31'h0, ((dv_cyc_last - dv_cyc_prev) >= 10 * CPB - 5 &&
                   (dv_cyc_last - dv_cyc_prev) <= 10 * CPB + 5)}, 32'h1);
    drive_bit(1'b1, CPB);

    // Short low glitch on an idle line.
    act_seen = 1'b0;
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 2 * CPB);
    check("glitch_active_seen", {31'h0, act_seen}, 32'h0);
    check_model("glitch");

    // 0x3C with a low stop bit, then idle.
    send_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b1, CPB);
    check_model("frame_err");

    // Reset asserted during data bit 4 of 0x5A.
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(logic'((8'h5A >> i) & 8'h1), CPB);
    drive_bit(1'b1, CPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("mid_reset");
    rst = 1'b0;
    exp_byte = '0;
    drive_bit(1'b1, 2 * CPB);
    check_model("post_reset_idle");
    send_frame(8'h81, 1'b1, 1'b0);
    drive_bit(1'b1, CPB);
    check_model("post_reset_81");

    // Break: line low for 12 bit times gives a single frame error.
    drive_bit(1'b0, 12 * CPB);
    exp_fe++;
    drive_bit(1'b1, 2 * CPB);
    check_model("break");
    send_frame(8'h5A, 1'b1, 1'b0);
    drive_bit(1'b1, CPB);
    check_model("after_break");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    drive_bit(1'b1, CPB);
    check_model("parity_good");
    send_frame(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1, CPB);
    check_model("parity_bad");
`endif

    // Randomized stream with random gaps and occasional bad stop bits.
    for (int n = 0; n < 30; n++) begin
      logic [DW-1:0] d;
      logic bad_stop;
      d = DW'($urandom_range(0, 255));
      bad_stop = ($urandom_range(0, 7) == 0);
      send_frame(d, ~bad_stop, 1'b0);
      check_model("rand");
      if (bad_stop) drive_bit(1'b1, CPB + int'($urandom_range(0, CPB)));
      else          drive_bit(1'b1, int'($urandom_range(0, 2 * CPB)));
    end

    check("dv_with_error_overlap", both_count, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
